level_code_game: RTL and testbench
==================================

# level_code_game

Parametrised code-entry level game: the player presents a DATA_W-bit code on `data`, pulses `submit` to check it against the current level's secret, and pulses `nextLevel` to advance after a correct entry. Generalises the fixed 4-bit single-mode game with:
- configurable code width and level count;
- a per-level attempt limit with a timed lockout;
- a win state;
- edge-detected controls and reported level and tries.

It sits directly under the board top, between debounced switch/button inputs and the status LEDs.

## Interface
- DATA_W, 4, code width in bits (>=2)
- LEVELS, 4, number of levels (>=2)
- MAX_TRIES, 3, wrong submits allowed per level before lockout (>=1)
- LOCK_CYCLES, 8, lockout duration in clk cycles (>=2)

- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- data  in  DATA_W  player code
- submit  in  1  check request, synchronous level signal, acts on rising edge
- nextLevel  in  1  advance/restart request, acts on rising edge
- out  out  3  status: 0 ENTRY, 1 CORRECT, 2 WRONG, 3 LOCKOUT, 4 WIN
- level  out  LVL_W  current level index, LVL_W = max(1, $clog2(LEVELS))
- tries_left  out  TRY_W  remaining attempts, TRY_W = $clog2(MAX_TRIES+1)

## Operation
- **Edge detection.** `sub_q` and `nxt_q` are the inputs registered every cycle.
  - sub_edge = submit & ~sub_q.
  - nxt_edge = nextLevel & ~nxt_q.
  - A held button acts once.
- **Secret code.** secret(k) = (5*k + 3) mod 2^DATA_W, computed at DATA_W width.
- **States.** Equal to `out`: ENTRY, CORRECT, WRONG, LOCKOUT, WIN.
- **ENTRY or WRONG, on sub_edge:**
  - If data == secret(level): go to CORRECT.
  - Else, if tries_left > 1: tries_left decrements and state goes to WRONG.
  - Else (tries_left == 1): tries_left becomes 0, state goes to LOCKOUT, and timer loads LOCK_CYCLES-1.
- **CORRECT, on nxt_edge:**
  - If level < LEVELS-1: level increments, tries_left becomes MAX_TRIES, state goes to ENTRY.
  - Else: go to WIN.
  - sub_edge in CORRECT is ignored.
- **LOCKOUT:**
  - The timer decrements each cycle; submit and nextLevel are ignored.
  - When timer == 0: state goes to ENTRY, level becomes 0, tries_left becomes MAX_TRIES.
- **WIN:** holds. nxt_edge restarts the game: level 0, tries_left MAX_TRIES, state ENTRY.
- **Simultaneous edges:** the edge relevant to the current state wins. nxt_edge is used in CORRECT/WIN, sub_edge in ENTRY/WRONG; the other edge is dropped.
- **`data` sampling:** `data` is sampled in the same cycle as sub_edge.

## Timing
- **Reset values (asynchronous on rst_n low):**
  - out=0 (ENTRY), level=0, tries_left=MAX_TRIES, timer=0.
  - sub_q=0, nxt_q=0, so an input held high through reset produces an edge on the first cycle after release.
- **Latency:** an input rising in cycle n is seen as an edge in cycle n. The state, level and tries_left update at the clk edge ending cycle n, i.e. one clock later.
- **Outputs:** all outputs are registered; no combinational input-to-output path.
- **Lockout length:** LOCKOUT is visible on `out` for exactly LOCK_CYCLES cycles, then ENTRY.
- **Reset mid-operation:** reset in any state, including mid-lockout, returns immediately to the reset values.

## Structure
- Package `level_game_pkg`:
  - state enum / localparams ST_ENTRY..ST_WIN (3 bits);
  - function secret_code(level, DATA_W).
- Sub-module `edge_detect` (1-bit register plus rising-edge output), instantiated twice.
- The top FSM, counters and timer live in level_code_game.

## Test plan
All scenarios use the default parameters: secrets are 3, 8, 13, 2.
1. **Reset:** hold rst_n low with submit=1 -> out=0, level=0, tries_left=3. Release -> one edge is evaluated.
2. **Correct path:**
   - data=3, pulse submit -> out=1 after one clock.
   - Pulse nextLevel -> level=1, out=0, tries_left=3.
   - Repeat with 8, 13, 2 -> out=4 (WIN).
   - Pulse nextLevel -> level=0, out=0.
3. **Lockout:** at level 2, submit data=0 three times.
   - tries_left goes 2 then 1 with out=2, then 0 with out=3.
   - out=3 lasts exactly 8 cycles, then out=0, level=0, tries_left=3.
   - Submits during lockout have no effect.
4. **Held buttons:** hold submit high for 10 cycles with a wrong code -> tries_left decrements only once.
5. **Simultaneous edges:**
   - In CORRECT, submit and nextLevel rising together -> level advances, no evaluation.
   - In ENTRY, both rising with a correct code -> out=1, level unchanged.
6. **Async reset mid-lockout:** assert rst_n low between clock edges -> outputs take reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/level_game_pkg.sv
// Shared state encoding and secret-code generator for the level code game.
package level_game_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CORRECT = 3'd1,
    ST_WRONG   = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_WIN     = 3'd4
  } state_t;

  // Secret for level k is (5k+3) reduced modulo 2^dw; the caller slices to its width.
  function automatic logic [31:0] secret_code(input logic [31:0] lvl, input int unsigned dw);
    logic [31:0] raw;
    logic [31:0] mask;
    raw  = (lvl * 32'd5) + 32'd3;
    mask = (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
    return raw & mask;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registers a level input and flags its rising edge in the same cycle it rises.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/level_code_game.sv
// Code-entry level game: per-level secret check, limited tries with timed lockout, win state.
// All outputs come straight from registers; controls act once per rising edge.
module level_code_game
  import level_game_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int LEVELS      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 8,
  localparam int LVL_W      = (LEVELS > 1) ? $clog2(LEVELS) : 1,
  localparam int TRY_W      = $clog2(MAX_TRIES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              submit,
  input  logic              nextLevel,
  output logic [2:0]        out,
  output logic [LVL_W-1:0]  level,
  output logic [TRY_W-1:0]  tries_left
);

  localparam int TMR_W = $clog2(LOCK_CYCLES);

  state_t            st_q, st_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              sub_rise;
  logic              nxt_rise;
  logic [DATA_W-1:0] secret;

  edge_detect u_sub_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (submit),
    .rise  (sub_rise)
  );

  edge_detect u_nxt_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (nextLevel),
    .rise  (nxt_rise)
  );

  assign secret = DATA_W'(secret_code(32'(lvl_q), DATA_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_ENTRY;
      lvl_q   <= '0;
      tries_q <= TRY_W'(MAX_TRIES);
      tmr_q   <= '0;
    end else begin
      st_q    <= st_d;
      lvl_q   <= lvl_d;
      tries_q <= tries_d;
      tmr_q   <= tmr_d;
    end
  end

  // Each state only listens to its own edge, so a simultaneous other edge is dropped.
  always_comb begin
    st_d    = st_q;
    lvl_d   = lvl_q;
    tries_d = tries_q;
    tmr_d   = tmr_q;
    case (st_q)
      ST_ENTRY, ST_WRONG: begin
        if (sub_rise) begin
          if (data == secret) begin
            st_d = ST_CORRECT;
          end else if (tries_q > TRY_W'(1)) begin
            tries_d = tries_q - TRY_W'(1);
            st_d    = ST_WRONG;
          end else begin
            tries_d = '0;
            tmr_d   = TMR_W'(LOCK_CYCLES - 1);
            st_d    = ST_LOCKOUT;
          end
        end
      end
      ST_CORRECT: begin
        if (nxt_rise) begin
          if (lvl_q < LVL_W'(LEVELS - 1)) begin
            lvl_d   = lvl_q + LVL_W'(1);
            tries_d = TRY_W'(MAX_TRIES);
            st_d    = ST_ENTRY;
          end else begin
            st_d = ST_WIN;
          end
        end
      end
      ST_LOCKOUT: begin
        // Timer loaded with LOCK_CYCLES-1 so LOCKOUT is held for exactly LOCK_CYCLES cycles.
        if (tmr_q == '0) begin
          st_d    = ST_ENTRY;
          lvl_d   = '0;
          tries_d = TRY_W'(MAX_TRIES);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_WIN: begin
        if (nxt_rise) begin
          st_d    = ST_ENTRY;
          lvl_d   = '0;
          tries_d = TRY_W'(MAX_TRIES);
        end
      end
      default: begin
        st_d    = ST_ENTRY;
        lvl_d   = '0;
        tries_d = TRY_W'(MAX_TRIES);
        tmr_d   = '0;
      end
    endcase
  end

  assign out        = st_q;
  assign level      = lvl_q;
  assign tries_left = tries_q;

endmodule

// File: tb/tb_level_code_game.sv
// Directed bench for level_code_game at default parameters (secrets 3, 8, 13, 2).
module tb_level_code_game;

  logic       clk;
  logic       rst_n;
  logic [3:0] data;
  logic       submit;
  logic       nextLevel;
  logic [2:0] out;
  logic [1:0] level;
  logic [1:0] tries_left;

  int tests;
  int failures;

  level_code_game dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .submit     (submit),
    .nextLevel  (nextLevel),
    .out        (out),
    .level      (level),
    .tries_left (tries_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Raise submit for one clock, then leave it low for one clock so the next pulse is a fresh edge.
  task automatic pulse_submit(input logic [3:0] d);
    data   = d;
    submit = 1'b1;
    cycle();
    submit = 1'b0;
    cycle();
  endtask

  task automatic pulse_next();
    nextLevel = 1'b1;
    cycle();
    nextLevel = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; submit = 1'b1; nextLevel = 1'b0; data = 4'd3;
    cycle();
    cycle();
    tests++; if (out !== 3'd0) begin failures++; $display("FAIL reset_out got %0d want 0", out); end
    tests++; if (level !== 2'd0) begin failures++; $display("FAIL reset_level got %0d want 0", level); end
    tests++; if (tries_left !== 2'd3) begin failures++; $display("FAIL reset_tries got %0d want 3", tries_left); end
    rst_n = 1'b1;
    cycle();
    tests++; if (out !== 3'd1) begin failures++; $display("FAIL reset_held_submit_edge got %0d want 1", out); end
    cycle();
    tests++; if (out !== 3'd1) begin failures++; $display("FAIL reset_held_no_reeval got %0d want 1", out); end
    submit = 1'b0;
    rst_n  = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_correct_path();
    logic [3:0] codes [4];
    codes[0] = 4'd3; codes[1] = 4'd8; codes[2] = 4'd13; codes[3] = 4'd2;
    for (int k = 0; k < 4; k++) begin
      pulse_submit(codes[k]);
      tests++; if (out !== 3'd1) begin failures++; $display("FAIL correct_l%0d_out got %0d want 1", k, out); end
      pulse_next();
      if (k < 3) begin
        tests++; if (out !== 3'd0 || level !== 2'(k + 1) || tries_left !== 2'd3) begin
          failures++; $display("FAIL advance_l%0d got out=%0d lvl=%0d tries=%0d want 0/%0d/3", k, out, level, tries_left, k + 1);
        end
      end else begin
        tests++; if (out !== 3'd4 || level !== 2'd3) begin
          failures++; $display("FAIL win got out=%0d lvl=%0d want 4/3", out, level);
        end
      end
    end
    pulse_next();
    tests++; if (out !== 3'd0 || level !== 2'd0 || tries_left !== 2'd3) begin
      failures++; $display("FAIL restart got out=%0d lvl=%0d tries=%0d want 0/0/3", out, level, tries_left);
    end
  endtask

  task automatic test_lockout();
    pulse_submit(4'd3); pulse_next(); pulse_submit(4'd8); pulse_next();
    tests++; if (level !== 2'd2) begin failures++; $display("FAIL lock_setup_level got %0d want 2", level); end
    pulse_submit(4'd0);
    tests++; if (out !== 3'd2 || tries_left !== 2'd2) begin
      failures++; $display("FAIL wrong1 got out=%0d tries=%0d want 2/2", out, tries_left);
    end
    pulse_submit(4'd0);
    tests++; if (out !== 3'd2 || tries_left !== 2'd1) begin
      failures++; $display("FAIL wrong2 got out=%0d tries=%0d want 2/1", out, tries_left);
    end
    data = 4'd0; submit = 1'b1;
    cycle();
    tests++; if (out !== 3'd3 || tries_left !== 2'd0 || level !== 2'd2) begin
      failures++; $display("FAIL lock_enter got out=%0d tries=%0d lvl=%0d want 3/0/2", out, tries_left, level);
    end
    // Toggle both controls with the correct code during lockout; none of it may matter.
    for (int i = 1; i < 8; i++) begin
      data = 4'd13; submit = i[0]; nextLevel = i[0];
      cycle();
      tests++; if (out !== 3'd3 || tries_left !== 2'd0) begin
        failures++; $display("FAIL lock_cycle%0d got out=%0d tries=%0d want 3/0", i + 1, out, tries_left);
      end
    end
    submit = 1'b0; nextLevel = 1'b0;
    cycle();
    tests++; if (out !== 3'd0 || level !== 2'd0 || tries_left !== 2'd3) begin
      failures++; $display("FAIL lock_exit got out=%0d lvl=%0d tries=%0d want 0/0/3", out, level, tries_left);
    end
  endtask

  task automatic test_held_button();
    data = 4'd5; submit = 1'b1;
    repeat (10) cycle();
    tests++; if (out !== 3'd2 || tries_left !== 2'd2) begin
      failures++; $display("FAIL held_submit got out=%0d tries=%0d want 2/2", out, tries_left);
    end
    submit = 1'b0;
    cycle();
  endtask

  task automatic test_simultaneous();
    pulse_submit(4'd3);
    tests++; if (out !== 3'd1) begin failures++; $display("FAIL simul_setup got %0d want 1", out); end
    data = 4'd0; submit = 1'b1; nextLevel = 1'b1;
    cycle();
    tests++; if (out !== 3'd0 || level !== 2'd1 || tries_left !== 2'd3) begin
      failures++; $display("FAIL simul_correct got out=%0d lvl=%0d tries=%0d want 0/1/3", out, level, tries_left);
    end
    submit = 1'b0; nextLevel = 1'b0;
    cycle();
    data = 4'd8; submit = 1'b1; nextLevel = 1'b1;
    cycle();
    tests++; if (out !== 3'd1 || level !== 2'd1) begin
      failures++; $display("FAIL simul_entry got out=%0d lvl=%0d want 1/1", out, level);
    end
    submit = 1'b0; nextLevel = 1'b0;
    cycle();
  endtask

  task automatic test_async_reset_lockout();
    pulse_next();
    pulse_submit(4'd0); pulse_submit(4'd0);
    data = 4'd0; submit = 1'b1;
    cycle();
    submit = 1'b0;
    tests++; if (out !== 3'd3 || level !== 2'd2) begin
      failures++; $display("FAIL arst_setup got out=%0d lvl=%0d want 3/2", out, level);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out !== 3'd0 || level !== 2'd0 || tries_left !== 2'd3) begin
      failures++; $display("FAIL arst_immediate got out=%0d lvl=%0d tries=%0d want 0/0/3", out, level, tries_left);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    cycle();
    tests++; if (out !== 3'd0 || tries_left !== 2'd3) begin
      failures++; $display("FAIL arst_after got out=%0d tries=%0d want 0/3", out, tries_left);
    end
  endtask

  initial begin
    tests = 0; failures = 0;
    rst_n = 1'b0; data = '0; submit = 1'b0; nextLevel = 1'b0;
    @(negedge clk);
    test_reset();
    test_correct_path();
    test_lockout();
    test_held_button();
    test_simultaneous();
    test_async_reset_lockout();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
